in_port_fifo: RTL and testbench
===============================

Name: in_port_fifo

Overview:
- Input-device port that sits directly upstream of the processor's input bus.
- Accepts bytes from an external source (switch bank, serial receiver) into a small FIFO.
- Presents bytes one at a time to the processor using the four-phase in_dev_hs / in_dev_ack handshake.
- Decouples bursty device writes from the processor's stage-1 IN instruction timing.

Parameters:
AW, 2, FIFO address width; DEPTH = 2**AW entries (legal AW 1..4)
WIDTH, 8, data width; must match the processor input_bus
TIMEOUT, 255, handshake watchdog limit in cycles (used only with IN_PORT_TIMEOUT_EN)

Ports:
g_clk  input  1  global clock, all state updates on rising edge
g_clr  input  1  synchronous active-high reset
wr_en  input  1  device write strobe; one byte per cycle when high
wr_data  input  WIDTH  device byte
full  output  1  FIFO holds DEPTH entries (combinational from count)
count  output  AW+1  FIFO occupancy, 0..DEPTH (excludes byte in output register)
overflow  output  1  sticky; write attempted while full
in_dev_hs  output  1  data ready to processor (registered)
input_bus  output  WIDTH  byte offered to processor (registered)
in_dev_ack  input  1  processor has taken the byte
timeout  output  1  sticky; watchdog discarded a byte (0 when feature off)

Behaviour:
- Reset (g_clr high at an edge): count=0, read/write pointers=0, overflow=0, timeout=0, in_dev_hs=0, input_bus=0, state=S_IDLE. Reset mid-handshake drops in_dev_hs the next cycle, and all buffered data is lost.
- FIFO write: wr_en && !full pushes wr_data at wptr, wptr wraps modulo DEPTH. wr_en && full drops the byte and sets overflow; count is unchanged.
- Pop happens only on the S_IDLE->S_OFFER transition. Push and pop in the same cycle: count is unchanged, both pointers advance. Push to an empty FIFO is not visible to the FSM until the next cycle, so there is no fall-through.
- S_IDLE: in_dev_hs=0. If count>0: input_bus<=mem[rptr], rptr++, count--, in_dev_hs<=1, go to S_OFFER.
- S_OFFER: in_dev_hs=1; input_bus is held stable. When in_dev_ack=1 is sampled: in_dev_hs<=0, go to S_RELEASE.
- S_RELEASE: in_dev_hs=0. Stay until in_dev_ack=0 is sampled, then go to S_IDLE. A new offer therefore needs ack low for at least one edge.
- Latency: wr_en at edge n into an empty, idle port -> count=1 after n -> in_dev_hs=1 after n+1. Minimum of 3 cycles per byte between successive offers (OFFER, RELEASE, IDLE) when ack toggles promptly.
- in_dev_ack high while in S_IDLE is ignored. input_bus keeps the last offered byte after the handshake until the next load.
- full = (count==DEPTH). Pointers use AW bits. Count is AW+1 bits and never exceeds DEPTH.

Optional Feature:
- Macro IN_PORT_TIMEOUT_EN.
- Defined:
  - An AW-independent 8-bit cycle counter clears on entry to S_OFFER and increments each cycle in S_OFFER without ack.
  - On reaching TIMEOUT: the byte is discarded, in_dev_hs<=0, timeout<=1 (sticky until g_clr), and the FSM goes to S_IDLE.
  - Ack sampled on the same edge as the expiry takes priority; this is a normal completion.
- Not defined: S_OFFER waits indefinitely, the counter is not synthesized, and timeout is tied to 0.

Test Plan:
- Reset then single write 0xA5 at cycle 1 -> count=1 at cycle 2; in_dev_hs=1, input_bus=0xA5, count=0 at cycle 3. Ack at cycle 5 -> hs=0 at cycle 6. Ack low at cycle 7 -> S_IDLE.
- Write 0x11,0x22,0x33,0x44 back-to-back with ack held low (DEPTH=4). The first byte moves to the output register, so count=3 and full=0. Write 0x55 -> count=4, full=1. Write 0x66 -> overflow=1, count stays 4. Drain with handshakes -> the bus shows 0x11,0x22,0x33,0x44,0x55 in order.
- Simultaneous wr_en and pop with count=2 -> count stays 2; pointer wrap verified after 9 total writes.
- Hold ack high across S_RELEASE for 4 cycles with a second byte queued -> hs stays 0 until ack falls, then reasserts 2 cycles later with the next byte.
- Assert g_clr during S_OFFER with count=3 -> next cycle hs=0, count=0, input_bus=0, overflow=0.
- With IN_PORT_TIMEOUT_EN and TIMEOUT=8, offer 0x7E and never ack -> hs drops after 8 cycles, timeout=1, and the next queued byte is offered. Without the macro, hs stays 1 for more than 300 cycles.

Source files
------------

// File: rtl/in_port_fifo.sv
// Input-device port: buffers device bytes in a small FIFO and offers them to the processor over a four-phase hs/ack handshake.
// Optional handshake watchdog enabled by defining IN_PORT_TIMEOUT_EN.
module in_port_fifo #(
    parameter int unsigned AW      = 2,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             g_clk,
    input  logic             g_clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             in_dev_hs,
    output logic [WIDTH-1:0] input_bus,
    input  logic             in_dev_ack,
    output logic             timeout
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_OFFER   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    // Elaboration-time guard on parameter ranges (watchdog counter is 8 bits).
    if (AW < 1 || AW > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
        $error("in_port_fifo: AW must be 1..4 and TIMEOUT 1..255");
    end

    logic [1:0]       state, state_nxt;
    logic             hs_nxt;
    logic             pop;
    logic             push;
    logic [AW-1:0]    wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];

`ifdef IN_PORT_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] to_cnt;
    logic       expire;
`endif

    assign full = (count == CW'(DEPTH));
    assign push = wr_en && !full;

    // Next-state and handshake decode; pop only on the IDLE->OFFER transition.
    always_comb begin
        state_nxt = state;
        hs_nxt    = in_dev_hs;
        pop       = 1'b0;
`ifdef IN_PORT_TIMEOUT_EN
        expire    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                hs_nxt = 1'b0;
                if (count != '0) begin
                    pop       = 1'b1;
                    hs_nxt    = 1'b1;
                    state_nxt = S_OFFER;
                end
            end
            S_OFFER: begin
                hs_nxt = 1'b1;
                if (in_dev_ack) begin
                    hs_nxt    = 1'b0;
                    state_nxt = S_RELEASE;
`ifdef IN_PORT_TIMEOUT_EN
                end else if (to_cnt == TO_LAST) begin
                    expire    = 1'b1;
                    hs_nxt    = 1'b0;
                    state_nxt = S_IDLE;
`endif
                end
            end
            S_RELEASE: begin
                hs_nxt = 1'b0;
                if (!in_dev_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                hs_nxt    = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            state     <= S_IDLE;
            in_dev_hs <= 1'b0;
            input_bus <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_dev_hs <= hs_nxt;
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                input_bus <= mem[rptr];
                rptr      <= rptr + AW'(1);
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array carries no reset; contents are only read behind a valid count.
    always_ff @(posedge g_clk) begin
        if (push && !g_clr) begin
            mem[wptr] <= wr_data;
        end
    end

`ifdef IN_PORT_TIMEOUT_EN
    // Watchdog: cycles spent offering without an ack.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (pop) begin
                to_cnt <= '0;
            end else if (state == S_OFFER && !in_dev_ack) begin
                to_cnt <= to_cnt + 8'd1;
            end
            if (expire) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_in_port_fifo.sv
// Self-checking bench for in_port_fifo: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_in_port_fifo;

    localparam int unsigned AW         = 2;
    localparam int unsigned WIDTH      = 8;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned TB_TIMEOUT = 8;

    logic             g_clk = 1'b0;
    logic             g_clr = 1'b1;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             in_dev_ack = 1'b0;
    logic             full, overflow, in_dev_hs, timeout;
    logic [AW:0]      count;
    logic [WIDTH-1:0] input_bus;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 g_clk = ~g_clk;

    in_port_fifo #(.AW(AW), .WIDTH(WIDTH), .TIMEOUT(TB_TIMEOUT)) dut (
        .g_clk      (g_clk),
        .g_clr      (g_clr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .in_dev_hs  (in_dev_hs),
        .input_bus  (input_bus),
        .in_dev_ack (in_dev_ack),
        .timeout    (timeout)
    );

    // Reference model: byte queue plus handshake phase (0 idle, 1 offering, 2 waiting for ack low).
    logic [7:0] mq[$];
    logic       m_hs, m_ovf, m_tmo;
    logic [7:0] m_bus;
    int         m_phase;
    int         m_wait;

    typedef struct {
        logic       clr;
        logic       wr;
        logic [7:0] data;
        logic       ack;
        logic       hs;
        logic [7:0] bus;
        int         cnt;
        logic       full;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic clr, input logic wr, input logic [7:0] d, input logic ack);
        int pre;
        if (clr) begin
            mq.delete();
            m_hs = 1'b0; m_bus = '0; m_ovf = 1'b0; m_tmo = 1'b0;
            m_phase = 0; m_wait = 0;
            return;
        end
        pre = mq.size();
        case (m_phase)
            0: if (pre > 0) begin
                m_bus = mq.pop_front();
                m_hs = 1'b1; m_phase = 1; m_wait = 0;
            end
            1: begin
                if (ack) begin
                    m_hs = 1'b0; m_phase = 2;
                end
`ifdef IN_PORT_TIMEOUT_EN
                else begin
                    m_wait++;
                    if (m_wait >= TB_TIMEOUT) begin
                        m_hs = 1'b0; m_tmo = 1'b1; m_phase = 0;
                    end
                end
`endif
            end
            2: if (!ack) m_phase = 0;
            default: ;
        endcase
        if (wr) begin
            if (pre < DEPTH) mq.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic drive(input logic clr, input logic wr, input logic [7:0] d, input logic ack);
        g_clr = clr; wr_en = wr; wr_data = d; in_dev_ack = ack;
        @(posedge g_clk);
        model_step(clr, wr, d, ack);
        #1;
    endtask

    task automatic check_model();
        chk("hs", int'(in_dev_hs), int'(m_hs));
        chk("bus", int'(input_bus), int'(m_bus));
        chk("count", int'(count), mq.size());
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("timeout", int'(timeout), int'(m_tmo));
    endtask

    task automatic add(input logic clr, input logic wr, input logic [7:0] d, input logic ack,
                       input logic hs, input logic [7:0] bus, input int cnt, input logic f, input logic ovf);
        vec_t v;
        v.clr = clr; v.wr = wr; v.data = d; v.ack = ack;
        v.hs = hs; v.bus = bus; v.cnt = cnt; v.full = f; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs_cycles;

        // Single byte handshake, then fill/overflow/drain with DEPTH=4.
        add(1, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0);
        add(0, 1, 8'hA5, 0,  0, 8'h00, 1, 0, 0);
        add(0, 0, 8'h00, 0,  1, 8'hA5, 0, 0, 0);
        add(0, 0, 8'h00, 0,  1, 8'hA5, 0, 0, 0);
        add(0, 0, 8'h00, 1,  0, 8'hA5, 0, 0, 0);
        add(0, 0, 8'h00, 1,  0, 8'hA5, 0, 0, 0);
        add(0, 0, 8'h00, 0,  0, 8'hA5, 0, 0, 0);
        add(0, 0, 8'h00, 0,  0, 8'hA5, 0, 0, 0);
        add(0, 1, 8'h11, 0,  0, 8'hA5, 1, 0, 0);
        add(0, 1, 8'h22, 0,  1, 8'h11, 1, 0, 0);
        add(0, 1, 8'h33, 0,  1, 8'h11, 2, 0, 0);
        add(0, 1, 8'h44, 0,  1, 8'h11, 3, 0, 0);
        add(0, 1, 8'h55, 0,  1, 8'h11, 4, 1, 0);
        add(0, 1, 8'h66, 0,  1, 8'h11, 4, 1, 1);
        add(0, 0, 8'h00, 1,  0, 8'h11, 4, 1, 1);
        add(0, 0, 8'h00, 0,  0, 8'h11, 4, 1, 1);
        add(0, 0, 8'h00, 0,  1, 8'h22, 3, 0, 1);
        add(0, 0, 8'h00, 1,  0, 8'h22, 3, 0, 1);
        add(0, 0, 8'h00, 0,  0, 8'h22, 3, 0, 1);
        add(0, 0, 8'h00, 0,  1, 8'h33, 2, 0, 1);
        add(0, 0, 8'h00, 1,  0, 8'h33, 2, 0, 1);
        add(0, 0, 8'h00, 0,  0, 8'h33, 2, 0, 1);
        add(0, 0, 8'h00, 0,  1, 8'h44, 1, 0, 1);
        add(0, 0, 8'h00, 1,  0, 8'h44, 1, 0, 1);
        add(0, 0, 8'h00, 0,  0, 8'h44, 1, 0, 1);
        add(0, 0, 8'h00, 0,  1, 8'h55, 0, 0, 1);
        add(0, 0, 8'h00, 1,  0, 8'h55, 0, 0, 1);
        add(0, 0, 8'h00, 0,  0, 8'h55, 0, 0, 1);
        add(0, 0, 8'h00, 0,  0, 8'h55, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].wr, vecs[i].data, vecs[i].ack);
            chk($sformatf("vec%0d_hs", i), int'(in_dev_hs), int'(vecs[i].hs));
            chk($sformatf("vec%0d_bus", i), int'(input_bus), int'(vecs[i].bus));
            chk($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
            chk($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].full));
            chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].ovf));
            chk($sformatf("vec%0d_timeout", i), int'(timeout), 0);
        end

        // Simultaneous push and pop with two queued, then wrap pointers over nine writes.
        drive(1, 0, 8'h00, 0);
        drive(0, 1, 8'h01, 0); check_model();
        drive(0, 1, 8'h02, 0); check_model();
        drive(0, 1, 8'h03, 0); check_model();
        drive(0, 0, 8'h00, 1); check_model();
        drive(0, 0, 8'h00, 0); check_model();
        chk("pushpop_pre_count", int'(count), 2);
        drive(0, 1, 8'h04, 0); check_model();
        chk("pushpop_count", int'(count), 2);
        chk("pushpop_bus", int'(input_bus), 8'h02);
        for (int b = 5; b <= 9; b++) begin
            drive(0, 1, 8'(b), 1); check_model();
            drive(0, 0, 8'h00, 0); check_model();
            drive(0, 0, 8'h00, 0); check_model();
        end
        repeat (3) begin
            drive(0, 0, 8'h00, 1); check_model();
            drive(0, 0, 8'h00, 0); check_model();
            drive(0, 0, 8'h00, 0); check_model();
        end
        chk("wrap_last_byte", int'(input_bus), 8'h09);
        chk("wrap_empty", int'(count), 0);

        // Ack held high through RELEASE with a second byte waiting.
        drive(1, 0, 8'h00, 0);
        drive(0, 1, 8'hA1, 0); check_model();
        drive(0, 1, 8'hB2, 0); check_model();
        chk("rel_first_bus", int'(input_bus), 8'hA1);
        drive(0, 0, 8'h00, 1); check_model();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 8'h00, 1); check_model();
            chk($sformatf("rel_hold%0d_hs", i), int'(in_dev_hs), 0);
        end
        drive(0, 0, 8'h00, 0); check_model();
        chk("rel_idle_hs", int'(in_dev_hs), 0);
        drive(0, 0, 8'h00, 0); check_model();
        chk("rel_reoffer_hs", int'(in_dev_hs), 1);
        chk("rel_reoffer_bus", int'(input_bus), 8'hB2);

        // Reset while offering with three queued and overflow set.
        drive(1, 0, 8'h00, 0);
        for (int b = 0; b < 6; b++) begin
            drive(0, 1, 8'(8'hC1 + b), 0); check_model();
        end
        drive(0, 0, 8'h00, 1); check_model();
        drive(0, 0, 8'h00, 0); check_model();
        drive(0, 0, 8'h00, 0); check_model();
        chk("clr_pre_count", int'(count), 3);
        chk("clr_pre_ovf", int'(overflow), 1);
        drive(1, 0, 8'h00, 0);
        chk("clr_hs", int'(in_dev_hs), 0);
        chk("clr_count", int'(count), 0);
        chk("clr_bus", int'(input_bus), 0);
        chk("clr_ovf", int'(overflow), 0);

        // Offer never acknowledged.
        drive(1, 0, 8'h00, 0);
        drive(0, 1, 8'h7E, 0); check_model();
        drive(0, 1, 8'h3C, 0); check_model();
        chk("to_offer_bus", int'(input_bus), 8'h7E);
        hs_cycles = 1;
        for (int i = 0; i < 310; i++) begin
            drive(0, 0, 8'h00, 0); check_model();
            if (!in_dev_hs) break;
            hs_cycles++;
        end
`ifdef IN_PORT_TIMEOUT_EN
        chk("to_hs_cycles", hs_cycles, 8);
        chk("to_flag", int'(timeout), 1);
        drive(0, 0, 8'h00, 0); check_model();
        chk("to_next_hs", int'(in_dev_hs), 1);
        chk("to_next_bus", int'(input_bus), 8'h3C);
`else
        chk("no_to_hs_held", int'(hs_cycles > 300), 1);
        chk("no_to_flag", int'(timeout), 0);
`endif

        // Randomized traffic against the model.
        drive(1, 0, 8'h00, 0); check_model();
        for (int i = 0; i < 3000; i++) begin
            drive(logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 1)),
                  8'($urandom), logic'($urandom_range(0, 2) != 0));
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
